procyon_rom_loader: RTL and testbench
=====================================

Name: procyon_rom_loader

Overview:
Boot-time copy sequencer that drives the read port of the asynchronous-read ROM and streams its contents into a destination memory over a valid/ack write interface. Software or reset-sequencing logic issues a start command with a source word index and word count. The block walks the ROM, registers each word, and presents it as a write until acknowledged. It sits between the boot ROM and the memory/cache fill path.

Parameters:
OPTN_DATA_WIDTH, 32, ROM word width and destination write-data width
OPTN_ROM_DEPTH, 256, number of ROM words
OPTN_ADDR_WIDTH, 32, destination byte-address width
OPTN_DST_BASE_ADDR, 0, destination byte address of the first copied word
ROM_IDX_WIDTH, $clog2(OPTN_ROM_DEPTH), derived ROM index width
WORD_BYTES, OPTN_DATA_WIDTH/8, derived byte stride per word

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_start  input  1  start command, sampled only in IDLE
i_src_idx  input  ROM_IDX_WIDTH  first ROM word index
i_count  input  ROM_IDX_WIDTH+1  number of words to copy
o_busy  output  1  high in any state other than IDLE
o_done  output  1  one-cycle pulse on completion
o_error  output  1  one-cycle pulse on rejected command
o_rom_rd_addr  output  ROM_IDX_WIDTH  ROM read index
i_rom_data_out  input  OPTN_DATA_WIDTH  ROM combinational read data
o_wr_en  output  1  write valid
o_wr_addr  output  OPTN_ADDR_WIDTH  destination byte address
o_wr_data  output  OPTN_DATA_WIDTH  write data
i_wr_ack  input  1  write accepted when high together with o_wr_en

Behaviour:
- Reset (async, active-high): state IDLE. o_busy, o_done, o_error, o_wr_en = 0. o_rom_rd_addr, o_wr_addr, o_wr_data = 0. Internal index and remaining counters = 0. Reset mid-copy aborts immediately. No completion pulse. A partially written destination is permitted.
- States: IDLE, READ, WRITE, DONE.
- IDLE, i_start=1:
  - i_src_idx + i_count > OPTN_ROM_DEPTH (computed at ROM_IDX_WIDTH+2 bits, no wrap): pulse o_error next cycle, stay IDLE.
  - i_count == 0: go to DONE. No writes.
  - Otherwise: latch idx = i_src_idx, remaining = i_count, word offset = 0, go to READ.
- READ (1 cycle): o_rom_rd_addr = idx. At the clock edge, capture i_rom_data_out into o_wr_data. Set o_wr_addr = OPTN_DST_BASE_ADDR + offset*WORD_BYTES (truncated to OPTN_ADDR_WIDTH). Set o_wr_en = 1. Go to WRITE.
- WRITE:
  - While i_wr_ack=0, hold o_wr_en, o_wr_addr and o_wr_data stable.
  - On i_wr_ack=1: o_wr_en drops next cycle, idx++, offset++, remaining--.
  - If remaining was 1, go to DONE. Otherwise go to READ.
- DONE (1 cycle): o_done = 1, o_busy = 1. Next state IDLE.
- Timing: minimum 2 cycles per word (READ + WRITE with immediate ack). N words with ack always high finish in 2N cycles after start; o_done is asserted in cycle 2N+1.
- i_start outside IDLE is ignored. i_start in the DONE cycle is ignored, and is accepted in the following IDLE cycle.
- i_wr_ack while o_wr_en=0 is ignored.
- o_rom_rd_addr holds its last value outside READ. The ROM is never read out of range because commands are range-checked.
- o_busy=1 in READ, WRITE and DONE. o_busy=0 in IDLE, including the o_error pulse cycle.
- A copy reaching index OPTN_ROM_DEPTH-1 is legal (src=DEPTH-1, count=1). The idx increment after the last word is never used.

Test Plan:
- Reset mid-copy: assert rst during WRITE of word 2 of 4 -> all outputs 0 the same cycle. After release, IDLE with o_busy=0 and no o_done.
- Basic copy: ROM[i]=i*0x11111111, src=4, count=3, ack tied high -> writes (0x0,0x44444444), (0x4,0x55555555), (0x8,0x66666666). o_done pulses exactly 7 cycles after the start edge.
- Backpressure: ack held low 5 cycles on word 1 -> o_wr_en/o_wr_addr/o_wr_data stable all 5 cycles, exactly one write per word, 3 words total, then o_done.
- Boundary range: DEPTH=256, src=255, count=1 -> single write of ROM[255] then o_done. src=250, count=7 -> o_error pulse one cycle, no o_wr_en, o_busy stays 0.
- Zero count: src=10, count=0 -> o_done pulse one cycle later, no writes.
- Ignored start: i_start pulses during READ/WRITE with different src -> the original copy completes unchanged. A new start the cycle after o_done begins a new copy.

Source files
------------

// File: rtl/procyon_rom_loader.sv
// Boot-time ROM-to-memory copy sequencer: reads one ROM word per READ cycle and
// presents it on a valid/ack write port until the destination accepts it.
module procyon_rom_loader #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROM_DEPTH     = 256,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_DST_BASE_ADDR = 0,
  parameter int ROM_IDX_WIDTH      = $clog2(OPTN_ROM_DEPTH),
  parameter int WORD_BYTES         = OPTN_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [ROM_IDX_WIDTH-1:0]   i_src_idx,
  input  logic [ROM_IDX_WIDTH:0]     i_count,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [ROM_IDX_WIDTH-1:0]   o_rom_rd_addr,
  input  logic [OPTN_DATA_WIDTH-1:0] i_rom_data_out,
  output logic                       o_wr_en,
  output logic [OPTN_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [OPTN_DATA_WIDTH-1:0] o_wr_data,
  input  logic                       i_wr_ack
);

  // Write handshake: a word is transferred on a rising clk edge where o_wr_en
  // and i_wr_ack are both high; o_wr_addr/o_wr_data stay stable until then.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ROM_IDX_WIDTH+1:0]   DEPTH_EXT = (ROM_IDX_WIDTH+2)'(OPTN_ROM_DEPTH);
  localparam logic [OPTN_ADDR_WIDTH-1:0] DST_BASE  = OPTN_ADDR_WIDTH'(OPTN_DST_BASE_ADDR);
  localparam logic [OPTN_ADDR_WIDTH-1:0] STRIDE    = OPTN_ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ROM_IDX_WIDTH:0]     ONE_WORD  = {{ROM_IDX_WIDTH{1'b0}}, 1'b1};

  logic [1:0]                 state_q, state_d;
  logic [ROM_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [ROM_IDX_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ROM_IDX_WIDTH:0]     remaining_q, remaining_d;
  logic [ROM_IDX_WIDTH:0]     offset_q, offset_d;
  logic [OPTN_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [OPTN_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                       error_q, error_d;

  // Range check is done two bits wider than the index so src+count cannot wrap.
  logic [ROM_IDX_WIDTH+1:0] cmd_end;
  logic                     cmd_bad;
  assign cmd_end = {2'b00, i_src_idx} + {1'b0, i_count};
  assign cmd_bad = cmd_end > DEPTH_EXT;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    offset_d    = offset_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    error_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (cmd_bad) begin
            error_d = 1'b1;
          end else if (i_count == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d       = i_src_idx;
            remaining_d = i_count;
            offset_d    = '0;
            state_d     = ST_READ;
          end
        end
      end
      ST_READ: begin
        rd_addr_d = idx_q;
        wr_data_d = i_rom_data_out;
        wr_addr_d = DST_BASE + OPTN_ADDR_WIDTH'(offset_q) * STRIDE;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (i_wr_ack) begin
          idx_d       = idx_q + 1'b1;
          offset_d    = offset_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == ONE_WORD) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      error_q     <= error_d;
    end
  end

  // The ROM sees the live index only while reading; otherwise the last read index.
  assign o_rom_rd_addr = (state_q == ST_READ) ? idx_q : rd_addr_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_error       = error_q;
  assign o_wr_en       = (state_q == ST_WRITE);
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;

endmodule

// File: tb/tb_procyon_rom_loader.sv
// Bench for procyon_rom_loader: directed scenarios with literal expectations plus
// randomized commands and backpressure checked every cycle against a timing model.
module tb_procyon_rom_loader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_src_idx;
  logic [8:0]  i_count;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [7:0]  o_rom_rd_addr;
  logic [31:0] i_rom_data_out;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        i_wr_ack;

  logic [31:0] rom [256];
  assign i_rom_data_out = rom[o_rom_rd_addr];

  procyon_rom_loader dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_src_idx      (i_src_idx),
    .i_count        (i_count),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_rom_rd_addr  (o_rom_rd_addr),
    .i_rom_data_out (i_rom_data_out),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .i_wr_ack       (i_wr_ack)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];   // pending {addr, data} writes of the active copy
  logic [63:0] wr_log[$];  // every write the DUT completed
  int          done_log[$];
  int          err_log[$];
  bit          active      = 1'b0;
  int          done_cyc    = -1;
  int          err_cyc     = -1;
  int          next_wr_cyc = 0;

  int ack_mode = 0;  // 0: always ack, 1: random ack, 2: scripted stall on word 1
  int bp_base  = 0;
  int stall    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Timing rules: first write visible 2 cycles after the start edge, each accepted
  // write is followed by one idle-write cycle, completion 1 cycle after the last ack.
  initial begin
    bit exp_wr_en;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_flags", {o_busy, o_done, o_error, o_wr_en}, 64'h0);
        chk("rst_wr_beat", {o_wr_addr, o_wr_data}, 64'h0);
        chk("rst_rd_addr", o_rom_rd_addr, 64'h0);
        active   = 1'b0;
        done_cyc = -1;
        err_cyc  = -1;
        exp_q.delete();
      end else begin
        exp_wr_en = active && (exp_q.size() > 0) && (cyc >= next_wr_cyc);
        chk("wr_en", o_wr_en, exp_wr_en);
        if (exp_wr_en) chk("wr_beat", {o_wr_addr, o_wr_data}, exp_q[0]);
        chk("done", o_done, cyc == done_cyc);
        chk("error", o_error, cyc == err_cyc);
        chk("busy", o_busy, active);
        if (o_wr_en && i_wr_ack) wr_log.push_back({o_wr_addr, o_wr_data});
        if (o_done) done_log.push_back(cyc);
        if (o_error) err_log.push_back(cyc);
        if (exp_wr_en && i_wr_ack) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_cyc = cyc + 1;
          else next_wr_cyc = cyc + 2;
        end
        if (active && cyc == done_cyc) begin
          active = 1'b0;
        end else if (!active && i_start) begin
          if (int'(i_src_idx) + int'(i_count) > 256) begin
            err_cyc = cyc + 1;
          end else if (i_count == 9'd0) begin
            active   = 1'b1;
            done_cyc = cyc + 1;
          end else begin
            active      = 1'b1;
            done_cyc    = -1;
            next_wr_cyc = cyc + 2;
            for (int k = 0; k < int'(i_count); k++)
              exp_q.push_back({32'(k * 4), rom[int'(i_src_idx) + k]});
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- ack driver ----------------
  initial begin
    i_wr_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        1: i_wr_ack = ($urandom_range(0, 9) < 6);
        2: begin
          if (o_wr_en && (wr_log.size() - bp_base) == 1 && stall < 5) begin
            i_wr_ack = 1'b0;
            stall++;
          end else begin
            i_wr_ack = 1'b1;
          end
        end
        default: i_wr_ack = 1'b1;
      endcase
    end
  end

  // ---------------- command drivers ----------------
  task automatic cmd(input int src, input int cnt, output int s);
    s         = cyc;
    i_start   = 1'b1;
    i_src_idx = 8'(src);
    i_count   = 9'(cnt);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // junk: 0 none, 1 random ignored starts, 2 ignored start every busy cycle
  task automatic wait_idle(input int junk);
    for (int t = 0; t < 3000; t++) begin
      if (!active) return;
      if (junk == 2 || (junk == 1 && $urandom_range(0, 3) == 0)) begin
        i_start   = 1'b1;
        i_src_idx = 8'($urandom_range(0, 255));
        i_count   = 9'($urandom_range(1, 4));
      end
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    chk("idle_timeout", active, 64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s;
    int base;
    int dl;
    int src;
    int cnt;
    rst       = 1'b1;
    i_start   = 1'b0;
    i_src_idx = '0;
    i_count   = '0;
    for (int i = 0; i < 256; i++) rom[i] = 32'(i) * 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 64'h0);
    chk("reset_wr_en", o_wr_en, 64'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic copy, ack tied high
    base = wr_log.size();
    cmd(4, 3, s);
    wait_idle(0);
    chk("basic_nwrites", wr_log.size() - base, 64'd3);
    chk("basic_w0", wr_log[base],     {32'h0, 32'h4444_4444});
    chk("basic_w1", wr_log[base + 1], {32'h4, 32'h5555_5555});
    chk("basic_w2", wr_log[base + 2], {32'h8, 32'h6666_6666});
    chk("basic_done_cyc", done_log[$] - s, 64'd7);
    chk("basic_rd_addr_hold", o_rom_rd_addr, 64'd6);

    // backpressure: word 1 stalled for 5 cycles
    ack_mode = 2;
    stall    = 0;
    base     = wr_log.size();
    bp_base  = base;
    cmd(8, 3, s);
    wait_idle(0);
    ack_mode = 0;
    chk("bp_stalls", stall, 64'd5);
    chk("bp_nwrites", wr_log.size() - base, 64'd3);
    chk("bp_w0", wr_log[base],     {32'h0, 32'h8888_8888});
    chk("bp_w1", wr_log[base + 1], {32'h4, 32'h9999_9999});
    chk("bp_w2", wr_log[base + 2], {32'h8, 32'hAAAA_AAAA});
    chk("bp_done_cyc", done_log[$] - s, 64'd12);

    // last ROM word is a legal single-word copy
    base = wr_log.size();
    cmd(255, 1, s);
    wait_idle(0);
    chk("edge_nwrites", wr_log.size() - base, 64'd1);
    chk("edge_w0", wr_log[base], {32'h0, 32'hFFFF_FFEF});
    chk("edge_done_cyc", done_log[$] - s, 64'd3);

    // out-of-range command
    base = wr_log.size();
    dl   = done_log.size();
    cmd(250, 7, s);
    repeat (3) @(posedge clk);
    #1;
    chk("range_err_cyc", err_log[$] - s, 64'd1);
    chk("range_nwrites", wr_log.size() - base, 64'd0);
    chk("range_no_done", done_log.size() - dl, 64'd0);

    // zero count
    base = wr_log.size();
    cmd(10, 0, s);
    wait_idle(0);
    chk("zero_done_cyc", done_log[$] - s, 64'd1);
    chk("zero_nwrites", wr_log.size() - base, 64'd0);

    // starts while busy (and in the done cycle) are ignored; the next idle cycle accepts
    base = wr_log.size();
    cmd(20, 3, s);
    wait_idle(2);
    chk("ign_nwrites", wr_log.size() - base, 64'd3);
    chk("ign_w0", wr_log[base],     {32'h0, 32'h5555_5554});
    chk("ign_w1", wr_log[base + 1], {32'h4, 32'h6666_6665});
    chk("ign_w2", wr_log[base + 2], {32'h8, 32'h7777_7776});
    base = wr_log.size();
    cmd(30, 1, s);
    wait_idle(0);
    chk("back2back_w0", wr_log[base], {32'h0, 32'hFFFF_FFFE});
    chk("back2back_done_cyc", done_log[$] - s, 64'd3);

    // reset during the write of word 2 of 4
    cmd(0, 4, s);
    while (cyc < s + 4) begin
      @(posedge clk);
      #1;
    end
    chk("prerst_wr_en", o_wr_en, 64'h1);
    dl  = done_log.size();
    rst = 1'b1;
    #1;
    chk("midrst_flags", {o_busy, o_done, o_error, o_wr_en}, 64'h0);
    chk("midrst_wr_beat", {o_wr_addr, o_wr_data}, 64'h0);
    chk("midrst_rd_addr", o_rom_rd_addr, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_busy", o_busy, 64'h0);
    chk("postrst_no_done", done_log.size() - dl, 64'd0);

    // randomized commands, contents and backpressure
    ack_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
      src = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0) cnt = 256 - src + $urandom_range(0, 3);
      else cnt = $urandom_range(0, 12);
      cmd(src, cnt, s);
      wait_idle(1);
    end
    ack_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_exp_empty", exp_q.size(), 64'd0);
    chk("final_idle", o_busy, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
